// File: rtl/window_line_buffer_if.sv
// Pixel-stream in / 3x3-window out bundle for window_line_buffer.
// Master drives the raster stream; slave is the window generator.
`timescale 1ns/1ps
interface window_line_buffer_if #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned IMG_W  = 226,
  parameter int unsigned IMG_H  = 226
);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_sof;
  logic                  out_valid;
  logic [9*DATA_W-1:0]   out_window;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;
  logic                  frame_done;

  modport master (
    output in_valid, in_data, in_sof,
    input  out_valid, out_window, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_data, in_sof,
    output out_valid, out_window, out_row, out_col, frame_done
  );
endinterface

// File: rtl/window_line_buffer.sv
// 3x3 sliding-window generator over a raster pixel stream with two line memories.
// Define WLB_STRIDE2_EN to flag only stride-2 windows (even top-left row and column).
`timescale 1ns/1ps
module window_line_buffer #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned IMG_W  = 226,
  parameter int unsigned IMG_H  = 226
) (
  input  logic                  clk,
  input  logic                  reset,
  window_line_buffer_if.slave   bus
);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned WIN_W = 9 * DATA_W;

  logic [DATA_W-1:0] lm0 [IMG_W];
  logic [DATA_W-1:0] lm1 [IMG_W];
  logic [WIN_W-1:0]  win;
  logic [WIN_W-1:0]  win_nxt;
  logic [COL_W-1:0]  col_cnt, eff_col, nxt_col;
  logic [ROW_W-1:0]  row_cnt, eff_row, nxt_row;
  logic [DATA_W-1:0] lm0_rd, lm1_rd;
  logic              in_image, stride_ok, last_pix;

  // Position of the pixel on the bus; a qualified sof forces (0,0).
  always_comb begin
    eff_col  = (bus.in_sof) ? '0 : col_cnt;
    eff_row  = (bus.in_sof) ? '0 : row_cnt;
    lm0_rd   = lm0[eff_col];
    lm1_rd   = lm1[eff_col];
    in_image = (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
    last_pix = (eff_row == ROW_W'(IMG_H - 1)) && (eff_col == COL_W'(IMG_W - 1));
    nxt_col  = (eff_col == COL_W'(IMG_W - 1)) ? '0 : eff_col + COL_W'(1);
    nxt_row  = eff_row;
    if (eff_col == COL_W'(IMG_W - 1)) begin
      nxt_row = (eff_row == ROW_W'(IMG_H - 1)) ? '0 : eff_row + ROW_W'(1);
    end
`ifdef WLB_STRIDE2_EN
    // out_row = row-2 and out_col = col-2 share parity with row and col.
    stride_ok = ~eff_row[0] & ~eff_col[0];
`else
    stride_ok = 1'b1;
`endif
    // Each row shifts toward c=0; new c=2 column is {in_data, lm1, lm0} from bottom to top.
    win_nxt = {bus.in_data,
               win[8*DATA_W +: DATA_W], win[7*DATA_W +: DATA_W], lm1_rd,
               win[5*DATA_W +: DATA_W], win[4*DATA_W +: DATA_W], lm0_rd,
               win[2*DATA_W +: DATA_W], win[1*DATA_W +: DATA_W]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lm0            <= '{default: '0};
      lm1            <= '{default: '0};
      win            <= '0;
      col_cnt        <= '0;
      row_cnt        <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.out_row    <= '0;
      bus.out_col    <= '0;
    end else begin
      bus.out_valid  <= bus.in_valid && in_image && stride_ok;
      bus.frame_done <= bus.in_valid && last_pix;
      if (bus.in_valid) begin
        lm1[eff_col] <= bus.in_data;
        lm0[eff_col] <= lm1_rd;
        win          <= win_nxt;
        col_cnt      <= nxt_col;
        row_cnt      <= nxt_row;
        if (in_image) begin
          bus.out_row <= eff_row - ROW_W'(2);
          bus.out_col <= eff_col - COL_W'(2);
        end
      end
    end
  end

  assign bus.out_window = win;
endmodule
